// File: rtl/mem_arbiter.sv
// Two-lane MEM-stage arbiter onto one single-port data memory: lane 1 goes first, and a
// conflicting lane 2 access is held and replayed one cycle later. Loads return after 2 cycles.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          REQ1,
  input  logic          REQ2,
  input  logic          WE1,
  input  logic          WE2,
  input  logic [AW-1:0] ADDR1,
  input  logic [AW-1:0] ADDR2,
  input  logic [DW-1:0] WDATA1,
  input  logic [DW-1:0] WDATA2,
  output logic          STALL,
  output logic [DW-1:0] RDATA1,
  output logic [DW-1:0] RDATA2,
  output logic          RVALID1,
  output logic          RVALID2,
  output logic          MEM_EN,
  output logic          MEM_WE,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WDATA,
  input  logic [DW-1:0] MEM_RDATA,
  output logic [CW-1:0] CONFLICT_CNT
);

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic          r_we2;
  logic [AW-1:0] r_addr2;
  logic [DW-1:0] r_wdata2;

  logic          w_issue;
  logic          w_lane2;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_stall;
  logic          w_latch2;

  logic          r_ld_vld;
  logic          r_ld_lane2;
  logic [DW-1:0] r_rdata1;
  logic [DW-1:0] r_rdata2;
  logic          r_rvalid1;
  logic          r_rvalid2;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Everything is gated by RESET so a pending lane-2 replay never reaches memory.
  always_comb begin
    w_next   = r_state;
    w_issue  = 1'b0;
    w_lane2  = 1'b0;
    w_we     = 1'b0;
    w_addr   = '0;
    w_wdata  = '0;
    w_stall  = 1'b0;
    w_latch2 = 1'b0;
    if (!RESET) begin
      case (r_state)
        IDLE: begin
          if (REQ1) begin
            w_issue = 1'b1;
            w_we    = WE1;
            w_addr  = ADDR1;
            w_wdata = WDATA1;
            if (REQ2) begin
              w_stall  = 1'b1;
              w_latch2 = 1'b1;
              w_next   = SECOND;
            end
          end else if (REQ2) begin
            w_issue = 1'b1;
            w_lane2 = 1'b1;
            w_we    = WE2;
            w_addr  = ADDR2;
            w_wdata = WDATA2;
          end
        end
        SECOND: begin
          w_issue = 1'b1;
          w_lane2 = 1'b1;
          w_we    = r_we2;
          w_addr  = r_addr2;
          w_wdata = r_wdata2;
          w_next  = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_we2    <= 1'b0;
      r_addr2  <= '0;
      r_wdata2 <= '0;
    end else if (w_latch2) begin
      r_we2    <= WE2;
      r_addr2  <= ADDR2;
      r_wdata2 <= WDATA2;
    end
  end

  // Load return: tag the issue cycle, capture MEM_RDATA one cycle later, present it the next.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_ld_vld   <= 1'b0;
      r_ld_lane2 <= 1'b0;
      r_rvalid1  <= 1'b0;
      r_rvalid2  <= 1'b0;
      r_rdata1   <= '0;
      r_rdata2   <= '0;
    end else begin
      r_ld_vld   <= w_issue & ~w_we;
      r_ld_lane2 <= w_lane2;
      r_rvalid1  <= r_ld_vld & ~r_ld_lane2;
      r_rvalid2  <= r_ld_vld & r_ld_lane2;
      if (r_ld_vld && !r_ld_lane2) r_rdata1 <= MEM_RDATA;
      if (r_ld_vld && r_ld_lane2)  r_rdata2 <= MEM_RDATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET)                         r_cnt <= '0;
    else if (w_latch2 && r_cnt != '1) r_cnt <= r_cnt + CW'(1);
  end

  assign STALL        = w_stall;
  assign MEM_EN       = w_issue;
  assign MEM_WE       = w_we;
  assign MEM_ADDR     = w_addr;
  assign MEM_WDATA    = w_wdata;
  assign RDATA1       = r_rdata1;
  assign RDATA2       = r_rdata2;
  assign RVALID1      = r_rvalid1;
  assign RVALID2      = r_rvalid2;
  assign CONFLICT_CNT = r_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: memory issues and load returns are predicted at drive time
// and matched when the DUT produces them, against a behavioural single-port memory.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          REQ1, REQ2, WE1, WE2;
  logic [AW-1:0] ADDR1, ADDR2;
  logic [DW-1:0] WDATA1, WDATA2;
  logic          STALL;
  logic [DW-1:0] RDATA1, RDATA2;
  logic          RVALID1, RVALID2;
  logic          MEM_EN, MEM_WE;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_WDATA;
  logic [DW-1:0] MEM_RDATA = '0;
  logic [CW-1:0] CONFLICT_CNT;

  always #5 CLK = ~CLK;

  mem_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ1(REQ1), .REQ2(REQ2), .WE1(WE1), .WE2(WE2),
    .ADDR1(ADDR1), .ADDR2(ADDR2), .WDATA1(WDATA1), .WDATA2(WDATA2),
    .STALL(STALL), .RDATA1(RDATA1), .RDATA2(RDATA2),
    .RVALID1(RVALID1), .RVALID2(RVALID2),
    .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .CONFLICT_CNT(CONFLICT_CNT)
  );

  typedef struct {
    int            cyc;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } iss_t;

  typedef struct {
    int            cyc;
    logic [DW-1:0] d;
  } rd_t;

  iss_t          iss_q[$];
  rd_t           rd1_q[$];
  rd_t           rd2_q[$];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] phys [256];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_err = 0;
  int            exp_cnt = 0;

  function automatic logic [DW-1:0] init_val(int i);
    if (i == 16) return 32'hCAFE_0001;
    return 32'h5A00_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural single-port memory: read data appears the cycle after the read is issued.
  initial begin
    for (int i = 0; i < 256; i++) phys[i] = init_val(i);
    forever begin
      @(posedge CLK);
      if (MEM_EN) begin
        if (MEM_WE) phys[MEM_ADDR[7:0]] = MEM_WDATA;
        else        MEM_RDATA <= phys[MEM_ADDR[7:0]];
      end
    end
  end

  always @(negedge CLK) begin
    iss_t e;
    rd_t  r;
    if (MEM_EN) begin
      if (iss_q.size() == 0) check("issue_q_avail", 128'(iss_q.size()), 128'd1);
      else begin
        e = iss_q.pop_front();
        check("issue_cyc", 128'(cyc), 128'(e.cyc));
        check("issue_we", 128'(MEM_WE), 128'(e.we));
        check("issue_addr", 128'(MEM_ADDR), 128'(e.a));
        if (e.we) check("issue_wdata", 128'(MEM_WDATA), 128'(e.d));
      end
    end else begin
      check("idle_bus", 128'({MEM_WE, MEM_ADDR, MEM_WDATA}), 128'd0);
    end
    if (RVALID1 || RVALID2) check("rvalid_excl", 128'(RVALID1 & RVALID2), 128'd0);
    if (RVALID1) begin
      if (rd1_q.size() == 0) check("rd1_q_avail", 128'(rd1_q.size()), 128'd1);
      else begin
        r = rd1_q.pop_front();
        check("rd1_cyc", 128'(cyc), 128'(r.cyc));
        check("rd1_data", 128'(RDATA1), 128'(r.d));
      end
    end
    if (RVALID2) begin
      if (rd2_q.size() == 0) check("rd2_q_avail", 128'(rd2_q.size()), 128'd1);
      else begin
        r = rd2_q.pop_front();
        check("rd2_cyc", 128'(cyc), 128'(r.cyc));
        check("rd2_data", 128'(RDATA2), 128'(r.d));
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic r1, input logic w1, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d1, input logic r2, input logic w2,
                       input logic [AW-1:0] a2, input logic [DW-1:0] d2);
    REQ1 = r1; WE1 = w1; ADDR1 = a1; WDATA1 = d1;
    REQ2 = r2; WE2 = w2; ADDR2 = a2; WDATA2 = d2;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    repeat (n) step();
  endtask

  // Reference view of memory in program order; loads capture their expected data here.
  task automatic access(input int lane, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int rcyc);
    rd_t r;
    if (we) ref_mem[a[7:0]] = d;
    else begin
      r.cyc = rcyc;
      r.d   = ref_mem[a[7:0]];
      if (lane == 1) rd1_q.push_back(r);
      else           rd2_q.push_back(r);
    end
  endtask

  task automatic single(input int lane, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    if (lane == 1) drive(1'b1, we, a, d, 1'b0, 1'b0, '0, '0);
    else           drive(1'b0, 1'b0, '0, '0, 1'b1, we, a, d);
    iss_q.push_back('{cyc, we, a, d});
    access(lane, we, a, d, cyc + 2);
    @(negedge CLK);
    check("stall_single", 128'(STALL), 128'd0);
    step();
  endtask

  task automatic dual(input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic w2, input logic [AW-1:0] a2, input logic [DW-1:0] d2);
    drive(1'b1, w1, a1, d1, 1'b1, w2, a2, d2);
    iss_q.push_back('{cyc, w1, a1, d1});
    iss_q.push_back('{cyc + 1, w2, a2, d2});
    access(1, w1, a1, d1, cyc + 2);
    access(2, w2, a2, d2, cyc + 3);
    if (exp_cnt < CNT_MAX) exp_cnt++;
    @(negedge CLK);
    check("stall_dual", 128'(STALL), 128'd1);
    step();
    // Requests presented during the replay cycle must be ignored.
    drive(1'b1, 1'b1, AW'($urandom_range(0, 255)), $urandom,
          1'b1, 1'b0, AW'($urandom_range(0, 255)), $urandom);
    @(negedge CLK);
    check("stall_second", 128'(STALL), 128'd0);
    check("conflict_cnt", 128'(CONFLICT_CNT), 128'(exp_cnt));
    step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    RESET = 1'b1;
    repeat (3) step();
    @(negedge CLK);
    check("rst_stall", 128'(STALL), 128'd0);
    check("rst_mem_en", 128'(MEM_EN), 128'd0);
    check("rst_rvalid", 128'({RVALID1, RVALID2}), 128'd0);
    check("rst_rdata", 128'({RDATA1, RDATA2}), 128'd0);
    check("rst_cnt", 128'(CONFLICT_CNT), 128'd0);
    step();
    RESET = 1'b0;

    single(1, 1'b0, 32'h10, '0);
    idle(3);

    dual(1'b1, 32'h20, 32'h0000_AAAA, 1'b0, 32'h20, '0);
    idle(3);

    dual(1'b1, 32'h40, 32'd1, 1'b1, 32'h40, 32'd2);
    single(1, 1'b0, 32'h40, '0);
    idle(3);

    single(2, 1'b0, 32'h30, '0);
    single(2, 1'b1, 32'h31, 32'h1234_5678);
    single(2, 1'b0, 32'h31, '0);
    idle(3);

    for (int i = 0; i < 8; i++) single(1, 1'b0, AW'(32'h80 + i), '0);
    idle(3);

    for (int i = 0; i < 6; i++) single((i % 2) + 1, 1'b0, AW'(32'h90 + i), '0);
    idle(3);

    // Reset while lane 2 is pending and lane 1's load is in flight.
    drive(1'b1, 1'b0, 32'h50, '0, 1'b1, 1'b1, 32'h50, 32'hDEAD_BEEF);
    iss_q.push_back('{cyc, 1'b0, 32'h50, '0});
    @(negedge CLK);
    check("rstmid_stall_t", 128'(STALL), 128'd1);
    step();
    RESET = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge CLK);
    check("rstmid_stall_t1", 128'(STALL), 128'd0);
    check("rstmid_mem_en_t1", 128'(MEM_EN), 128'd0);
    step();
    RESET = 1'b0;
    exp_cnt = 0;
    @(negedge CLK);
    check("rstmid_rvalid", 128'({RVALID1, RVALID2}), 128'd0);
    check("rstmid_rdata", 128'({RDATA1, RDATA2}), 128'd0);
    check("rstmid_cnt", 128'(CONFLICT_CNT), 128'd0);
    check("rstmid_stall_t2", 128'(STALL), 128'd0);
    check("rstmid_mem_en_t2", 128'(MEM_EN), 128'd0);
    step();
    single(1, 1'b0, 32'h50, '0);
    idle(3);

    for (int i = 0; i < 5; i++)
      dual(i[0], AW'(32'h60 + i), DW'(32'h100 + i), ~i[0], AW'(32'h60 + i), DW'(32'h200 + i));
    single(1, 1'b0, 32'h60, '0);
    single(2, 1'b0, 32'h61, '0);
    idle(5);

    check("iss_q_drained", 128'(iss_q.size()), 128'd0);
    check("rd1_q_drained", 128'(rd1_q.size()), 128'd0);
    check("rd2_q_drained", 128'(rd2_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: AW, 32, address width of both lanes and memory port.
REQ-002 Parameter: DW, 32, data width of both lanes and memory port.
REQ-003 Parameter: CW, 16, width of the conflict counter.
REQ-004 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-005 Port: RESET  input  1  synchronous, active-high reset.
REQ-006 Port: REQ1 / REQ2  input  1  lane 1 (older) / lane 2 (younger) MEM-stage access request.
REQ-007 Port: WE1 / WE2  input  1  1 = store, 0 = load, per lane.
REQ-008 Port: ADDR1 / ADDR2  input  AW  access address per lane.
REQ-009 Port: WDATA1 / WDATA2  input  DW  store data per lane.
REQ-010 Port: STALL  output  1  combinational pipeline freeze request.
REQ-011 Port: RDATA1 / RDATA2  output  DW  registered load data per lane.
REQ-012 Port: RVALID1 / RVALID2  output  1  one-cycle pulse; the matching RDATA is new.
REQ-013 Port: MEM_EN, MEM_WE  output  1  single-port data memory enable and write enable.
REQ-014 Port: MEM_ADDR / MEM_WDATA  output  AW / DW  memory address and write data.
REQ-015 Port: MEM_RDATA  input  DW  memory read data, valid the cycle after a read is issued.
REQ-016 Port: CONFLICT_CNT  output  CW  count of dual-request cycles.

Function
REQ-017 The block SHALL have a two-state FSM: IDLE and SECOND.
REQ-018 In IDLE with only REQx=1, the block SHALL issue lane x to memory in that cycle with STALL=0 and remain in IDLE.
REQ-019 In IDLE with REQ1=REQ2=1, the block SHALL issue lane 1, drive STALL=1, latch lane 2's WE/ADDR/WDATA, and go to SECOND.
REQ-020 In SECOND, the block SHALL issue the latched lane 2 access, drive STALL=0, ignore the REQ inputs, and return to IDLE.
REQ-021 In IDLE with no request, the block SHALL drive MEM_EN=0 and STALL=0.
REQ-022 MEM_EN SHALL be 1 exactly in issue cycles; MEM_WE, MEM_ADDR and MEM_WDATA SHALL come from the issued lane; otherwise MEM_WE=0 and address/data SHALL be 0.
REQ-023 Program order SHALL be preserved: lane 1 always reaches memory before lane 2 of the same pair, so same-address store/load pairs resolve in lane order and the lane 2 store wins on a double store.
REQ-024 For a load issued in cycle T, the block SHALL capture MEM_RDATA at the end of T+1 into RDATAx and pulse RVALIDx=1 in T+2, giving a load latency of 2.
REQ-025 RDATAx SHALL hold its value until the next lane-x load returns; stores SHALL produce no RVALID.
REQ-026 Back-to-back loads SHALL be supported every cycle; RVALID1 and RVALID2 SHALL never be high in the same cycle.
REQ-027 CONFLICT_CNT SHALL increment by 1 on each IDLE cycle with REQ1=REQ2=1 and SHALL saturate at 2^CW-1 without wrapping.

Reset
REQ-028 While RESET=1, the block SHALL force the FSM to IDLE and drive MEM_EN=0, MEM_WE=0 and STALL=0.
REQ-029 While RESET=1, RDATA1, RDATA2, RVALID1, RVALID2, CONFLICT_CNT and the lane-2 latch SHALL clear to 0.
REQ-030 RESET asserted in SECOND SHALL drop the pending lane-2 access; no MEM_EN SHALL occur for it.
REQ-031 RESET asserted while a load is in flight SHALL suppress that load's RVALID pulse.

Verification
REQ-032 Single load: REQ1=1, WE1=0, ADDR1=0x10, MEM_RDATA=0xCAFE0001 in T+1 -> MEM_EN=1 with MEM_ADDR=0x10 in T; RVALID1=1 and RDATA1=0xCAFE0001 in T+2; STALL=0 throughout.
REQ-033 Dual request: lane 1 store 0xAAAA to 0x20 and lane 2 load from 0x20 in T -> STALL=1 in T; MEM_WE=1 with address 0x20 in T; MEM_WE=0 load with address 0x20 in T+1; RVALID2 in T+3; CONFLICT_CNT=1.
REQ-034 Double store: both lanes store to 0x40, WDATA1=1, WDATA2=2 -> two write cycles, lane 1 first, then lane 2 with data 2.
REQ-035 Reset mid-operation: dual request in T, RESET=1 in T+1 -> no MEM_EN in T+1, FSM in IDLE in T+2, all outputs 0.
REQ-036 Saturation: CW=2, five dual-request pairs -> CONFLICT_CNT sequence 1, 2, 3, 3, 3.
REQ-037 Streaming: lane 1 loads every cycle for 8 cycles -> 8 consecutive RVALID1 pulses two cycles after each issue, with correct data per cycle.
